// File: rtl/noc_packet_tx.sv
// rtl/noc_packet_tx.sv - NoC packet transmitter: request + payload stream to header/payload flits
// Optional checksum tail flit enabled by defining NOC_PACKET_TX_CHECKSUM_EN.
module noc_packet_tx #(
  parameter  int FLIT_WIDTH  = 32,
  parameter  int MAX_LEN     = 16,
  parameter  int DEST_WIDTH  = 5,
  parameter  int CLASS_WIDTH = 3,
  localparam int LW          = $clog2(MAX_LEN + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DEST_WIDTH-1:0]  req_dest,
  input  logic [CLASS_WIDTH-1:0] req_class,
  input  logic [LW-1:0]          req_len,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [FLIT_WIDTH-1:0]  pl_data,
  input  logic                   pl_valid,
  output logic                   pl_ready,
  output logic [FLIT_WIDTH-1:0]  out_flit,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   err_len
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
`ifdef NOC_PACKET_TX_CHECKSUM_EN
    ,TAIL   = 2'd3
`endif
  } state_t;

`ifdef NOC_PACKET_TX_CHECKSUM_EN
  localparam state_t END_ST   = TAIL;
  localparam bit     HAS_TAIL = 1'b1;
`else
  localparam state_t END_ST   = IDLE;
  localparam bit     HAS_TAIL = 1'b0;
`endif

  localparam logic [LW-1:0] MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] ONE_L     = LW'(1);

  state_t                 state_q, state_d;
  logic [DEST_WIDTH-1:0]  dest_q, dest_d;
  logic [CLASS_WIDTH-1:0] class_q, class_d;
  logic [LW-1:0]          len_q, len_d;
  logic [LW-1:0]          rem_q, rem_d;
  logic [FLIT_WIDTH-1:0]  flit_q, flit_d;
  logic                   last_q, last_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
`ifdef NOC_PACKET_TX_CHECKSUM_EN
  logic [FLIT_WIDTH-1:0]  csum_q, csum_d;
`endif

  logic                  slot_free;
  logic                  ld_hdr;
  logic [FLIT_WIDTH-1:0] ld_flit;
  logic [LW-1:0]         ld_len;

  function automatic logic [FLIT_WIDTH-1:0] mk_hdr(
    input logic [DEST_WIDTH-1:0]  d,
    input logic [CLASS_WIDTH-1:0] c,
    input logic [LW-1:0]          l
  );
    logic [FLIT_WIDTH-1:0] h;
    h = '0;
    h[FLIT_WIDTH-1 -: DEST_WIDTH]               = d;
    h[FLIT_WIDTH-DEST_WIDTH-1 -: CLASS_WIDTH]   = c;
    h[LW-1:0]                                   = l;
    return h;
  endfunction

  assign slot_free = ~valid_q | out_ready;

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    class_d   = class_q;
    len_d     = len_q;
    rem_d     = rem_q;
    flit_d    = flit_q;
    last_d    = last_q;
    valid_d   = valid_q & ~out_ready;
    err_d     = 1'b0;
    req_ready = 1'b0;
    pl_ready  = 1'b0;
    ld_hdr    = 1'b0;
    ld_flit   = '0;
    ld_len    = '0;
`ifdef NOC_PACKET_TX_CHECKSUM_EN
    csum_d    = csum_q;
`endif

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_len > MAX_LEN_L) begin
            err_d = 1'b1;
          end else begin
            dest_d  = req_dest;
            class_d = req_class;
            len_d   = req_len;
            rem_d   = req_len;
            // Loading the header straight from the request keeps back-to-back packets bubble-free.
            if (slot_free) begin
              ld_hdr  = 1'b1;
              ld_flit = mk_hdr(req_dest, req_class, req_len);
              ld_len  = req_len;
            end else begin
              state_d = HEADER;
            end
          end
        end
      end
      HEADER: begin
        if (slot_free) begin
          ld_hdr  = 1'b1;
          ld_flit = mk_hdr(dest_q, class_q, len_q);
          ld_len  = len_q;
        end
      end
      PAYLOAD: begin
        pl_ready = slot_free;
        if (pl_valid && slot_free) begin
          valid_d = 1'b1;
          flit_d  = pl_data;
          rem_d   = rem_q - ONE_L;
          last_d  = (rem_q == ONE_L) && !HAS_TAIL;
`ifdef NOC_PACKET_TX_CHECKSUM_EN
          csum_d  = csum_q ^ pl_data;
`endif
          if (rem_q == ONE_L) state_d = END_ST;
        end
      end
`ifdef NOC_PACKET_TX_CHECKSUM_EN
      TAIL: begin
        if (slot_free) begin
          valid_d = 1'b1;
          flit_d  = csum_q;
          last_d  = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (ld_hdr) begin
      valid_d = 1'b1;
      flit_d  = ld_flit;
`ifdef NOC_PACKET_TX_CHECKSUM_EN
      csum_d  = ld_flit;
`endif
      if (ld_len == '0) begin
        last_d  = !HAS_TAIL;
        state_d = END_ST;
      end else begin
        last_d  = 1'b0;
        state_d = PAYLOAD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
      class_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      flit_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef NOC_PACKET_TX_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      class_q <= class_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      flit_q  <= flit_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef NOC_PACKET_TX_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign out_flit  = flit_q;
  assign out_last  = last_q;
  assign out_valid = valid_q;
  assign err_len   = err_q;
  assign busy      = (state_q != IDLE) | valid_q;

endmodule
